// File: rtl/warp_pkg.sv
// rtl/warp_pkg.sv - shared encodings, FSM states and alignment helper for the LSU data memory
package warp_pkg;

   localparam logic [1:0] WIDTH_BYTE   = 2'b00;
   localparam logic [1:0] WIDTH_HALF   = 2'b01;
   localparam logic [1:0] WIDTH_WORD   = 2'b10;
   localparam logic [1:0] WIDTH_DOUBLE = 2'b11;

   localparam logic LSU_OP_READ  = 1'b0;
   localparam logic LSU_OP_WRITE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] align_mask(input logic [1:0] width);
      case (width)
         WIDTH_BYTE: align_mask = 3'b000;
         WIDTH_HALF: align_mask = 3'b001;
         WIDTH_WORD: align_mask = 3'b011;
         default:    align_mask = 3'b111;
      endcase
   endfunction

endpackage

// File: rtl/warp_dmem_array.sv
// rtl/warp_dmem_array.sv - DEPTH x 64 synchronous RAM, byte-enable write, registered read
module warp_dmem_array #(
   parameter int DEPTH = 512,
   parameter int IW    = 9
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic          i_re,
   input  logic [IW-1:0] i_addr,
   input  logic [7:0]    i_be,
   input  logic [63:0]   i_wdata,
   output logic [63:0]   o_rdata
);

   logic [63:0] mem_q [DEPTH];
   logic [63:0] rdata_q;

   // Byte-lane writes and a read register that holds until the next read.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < 8; b++) begin
            if (i_be[b]) begin
               mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
      if (i_re) begin
         rdata_q <= mem_q[i_addr];
      end
   end

   assign o_rdata = rdata_q;

endmodule

// File: rtl/warp_dmem.sv
// rtl/warp_dmem.sv - LSU data-memory responder; optional range check via WARP_DMEM_BOUNDS_EN
module warp_dmem #(
   parameter int          DEPTH     = 512,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
   parameter int          LATENCY   = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_opsel,
   input  logic [63:0] i_req_addr,
   input  logic [1:0]  i_req_width,
   input  logic [63:0] i_req_wdata,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic        o_rsp_fault,
   output logic [63:0] o_rsp_rdata
);
   import warp_pkg::*;

   localparam int IW = $clog2(DEPTH);
   localparam int CW = 3;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           op_q, op_d;
   logic [63:0]    addr_q, addr_d;
   logic [1:0]     width_q, width_d;
   logic [63:0]    wdata_q, wdata_d;
   logic           fault_q, fault_d;
   logic           enter_resp;

   logic           cur_op;
   logic [63:0]    cur_addr;
   logic [1:0]     cur_width;
   logic [63:0]    cur_wdata;
   logic           cur_fault;
   logic [IW-1:0]  cur_idx;
   logic [7:0]     be_base;
   logic           ram_we, ram_re;
   logic [7:0]     ram_be;
   logic [63:0]    ram_wdata, ram_rdata;
   logic [63:0]    rd_mask, rd_shift;

   // Handshake FSM and latency counter; the RAM access happens on the edge entering RESP.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      addr_d      = addr_q;
      width_d     = width_q;
      wdata_d     = wdata_q;
      enter_resp  = 1'b0;
      o_req_ready = 1'b0;
      o_rsp_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               op_d    = i_req_opsel;
               addr_d  = i_req_addr;
               width_d = i_req_width;
               wdata_d = i_req_wdata;
               if (LATENCY == 1) begin
                  state_d    = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CW'(LATENCY - 1);
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d    = ST_RESP;
               enter_resp = 1'b1;
            end
         end
         ST_RESP: begin
            o_rsp_valid = 1'b1;
            if (i_rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request fields feeding the RAM: live inputs when RESP follows the accept directly.
   always_comb begin
      cur_op    = (state_q == ST_IDLE) ? i_req_opsel : op_q;
      cur_addr  = (state_q == ST_IDLE) ? i_req_addr  : addr_q;
      cur_width = (state_q == ST_IDLE) ? i_req_width : width_q;
      cur_wdata = (state_q == ST_IDLE) ? i_req_wdata : wdata_q;
      cur_idx   = IW'((cur_addr - BASE_ADDR) >> 3);
      cur_fault = |(cur_addr[2:0] & align_mask(cur_width));
`ifdef WARP_DMEM_BOUNDS_EN
      if ((cur_addr - BASE_ADDR) >= (64'(DEPTH) << 3)) begin
         cur_fault = 1'b1;
      end
`endif
      case (cur_width)
         WIDTH_BYTE: be_base = 8'h01;
         WIDTH_HALF: be_base = 8'h03;
         WIDTH_WORD: be_base = 8'h0F;
         default:    be_base = 8'hFF;
      endcase
      ram_be    = be_base << cur_addr[2:0];
      ram_wdata = cur_wdata << {cur_addr[2:0], 3'b000};
      ram_we    = enter_resp && (cur_op == LSU_OP_WRITE) && !cur_fault && i_rst_n;
      ram_re    = enter_resp && (cur_op == LSU_OP_READ) && !cur_fault;
      fault_d   = enter_resp ? cur_fault : fault_q;
   end

   // Right-justify and zero-extend the read word for the response.
   always_comb begin
      case (width_q)
         WIDTH_BYTE: rd_mask = 64'h0000_0000_0000_00FF;
         WIDTH_HALF: rd_mask = 64'h0000_0000_0000_FFFF;
         WIDTH_WORD: rd_mask = 64'h0000_0000_FFFF_FFFF;
         default:    rd_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      rd_shift    = ram_rdata >> {addr_q[2:0], 3'b000};
      o_rsp_fault = (state_q == ST_RESP) && fault_q;
      o_rsp_rdata = '0;
      if ((state_q == ST_RESP) && (op_q == LSU_OP_READ) && !fault_q) begin
         o_rsp_rdata = rd_shift & rd_mask;
      end
   end

   // State and latched request registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= LSU_OP_READ;
         addr_q  <= '0;
         width_q <= WIDTH_BYTE;
         wdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         width_q <= width_d;
         wdata_q <= wdata_d;
         fault_q <= fault_d;
      end
   end

   warp_dmem_array #(
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_array (
      .i_clk   (i_clk),
      .i_we    (ram_we),
      .i_re    (ram_re),
      .i_addr  (cur_idx),
      .i_be    (ram_be),
      .i_wdata (ram_wdata),
      .o_rdata (ram_rdata)
   );

endmodule

// File: tb/tb_warp_dmem.sv
// tb/tb_warp_dmem.sv - scoreboard bench for warp_dmem with directed vectors
module tb_warp_dmem;
   import warp_pkg::*;

   localparam int          DEPTH = 512;
   localparam logic [63:0] BASE  = 64'h8000_0000;
   localparam int          LAT   = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_opsel = 1'b0;
   logic [63:0] req_addr = '0;
   logic [1:0]  req_width = '0;
   logic [63:0] req_wdata = '0;
   logic        rsp_ready = 1'b1;
   logic        o_req_ready, o_rsp_valid, o_rsp_fault;
   logic [63:0] o_rsp_rdata;

   warp_dmem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .o_req_ready (o_req_ready),
      .i_req_opsel (req_opsel),
      .i_req_addr  (req_addr),
      .i_req_width (req_width),
      .i_req_wdata (req_wdata),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_fault (o_rsp_fault),
      .o_rsp_rdata (o_rsp_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   int rsp_id = 0;

   typedef struct {
      logic        fault;
      logic [63:0] rdata;
      int          acc;
      int          id;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   logic prev_v = 1'b0;

   task automatic check(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s #%0d: got %h expected %h", name, id, act, exp);
      end
   endtask

   // Monitor: latency on first valid cycle, payload on handshake.
   always @(negedge clk) begin
      if (o_rsp_valid && !prev_v && q.size() > 0) begin
         check("latency", q[0].id, 64'(cyc + 1 - q[0].acc), 64'(LAT));
      end
      if (o_rsp_valid && rsp_ready) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected response: fault %b rdata %h", o_rsp_fault, o_rsp_rdata);
         end else begin
            mon_e = q.pop_front();
            check("fault", mon_e.id, 64'(o_rsp_fault), 64'(mon_e.fault));
            check("rdata", mon_e.id, o_rsp_rdata, mon_e.rdata);
         end
      end
      prev_v = o_rsp_valid;
   end

   task automatic issue(input logic op, input logic [63:0] addr, input logic [1:0] w,
                        input logic [63:0] wd, input logic ef, input logic [63:0] ed, input bit push);
      exp_t e;
      int   n;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_opsel = op;
      req_addr  = addr;
      req_width = w;
      req_wdata = wd;
      n = 0;
      while (!o_req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!o_req_ready) begin
         tests++;
         fails++;
         $display("FAIL accept timeout: o_req_ready %b required 1", o_req_ready);
         req_valid = 1'b0;
         return;
      end
      if (push) begin
         e.fault = ef;
         e.rdata = ed;
         e.acc   = cyc + 1;
         e.id    = rsp_id;
         rsp_id++;
         q.push_back(e);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain timeout: %0d responses outstanding, required 0", q.size());
         q.delete();
      end
   endtask

   task automatic op(input logic o, input logic [63:0] addr, input logic [1:0] w,
                     input logic [63:0] wd, input logic ef, input logic [63:0] ed);
      issue(o, addr, w, wd, ef, ed, 1'b1);
      drain();
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      check("reset req_ready", 0, 64'(o_req_ready), 64'd1);
      check("reset rsp_valid", 0, 64'(o_rsp_valid), 64'd0);
      check("reset rsp_fault", 0, 64'(o_rsp_fault), 64'd0);
      check("reset rsp_rdata", 0, o_rsp_rdata, 64'd0);
      rst_n = 1'b1;

      // Double round trip
      op(LSU_OP_WRITE, BASE, WIDTH_DOUBLE, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0);
      op(LSU_OP_READ,  BASE, WIDTH_DOUBLE, 64'd0, 1'b0, 64'h0123_4567_89AB_CDEF);

      // Byte lane
      op(LSU_OP_WRITE, BASE,     WIDTH_DOUBLE, 64'd0,  1'b0, 64'd0);
      op(LSU_OP_WRITE, BASE + 5, WIDTH_BYTE,   64'h5A, 1'b0, 64'd0);
      op(LSU_OP_READ,  BASE,     WIDTH_DOUBLE, 64'd0,  1'b0, 64'h0000_5A00_0000_0000);
      op(LSU_OP_READ,  BASE + 5, WIDTH_BYTE,   64'd0,  1'b0, 64'h5A);

      // Misaligned write leaves memory untouched
      op(LSU_OP_WRITE, BASE + 2, WIDTH_WORD,   64'hFFFF_FFFF, 1'b1, 64'd0);
      op(LSU_OP_READ,  BASE,     WIDTH_DOUBLE, 64'd0, 1'b0, 64'h0000_5A00_0000_0000);

      // Sub-word reads and a misaligned half read
      op(LSU_OP_READ,  BASE + 4, WIDTH_HALF, 64'd0, 1'b0, 64'h5A00);
      op(LSU_OP_READ,  BASE + 4, WIDTH_WORD, 64'd0, 1'b0, 64'h5A00);
      op(LSU_OP_READ,  BASE + 3, WIDTH_HALF, 64'd0, 1'b1, 64'd0);

      // Backpressure
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      issue(LSU_OP_READ, BASE, WIDTH_DOUBLE, 64'd0, 1'b0, 64'h0000_5A00_0000_0000, 1'b1);
      n = 0;
      while (!o_rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("bp valid seen", 0, 64'(o_rsp_valid), 64'd1);
      repeat (5) begin
         @(negedge clk);
         check("bp valid/ready/fault", 0, 64'({o_rsp_valid, o_req_ready, o_rsp_fault}), 64'b100);
         check("bp rdata", 0, o_rsp_rdata, 64'h0000_5A00_0000_0000);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      drain();

      // Range check / wrap
`ifdef WARP_DMEM_BOUNDS_EN
      op(LSU_OP_READ, BASE + 64'(DEPTH * 8), WIDTH_DOUBLE, 64'd0, 1'b1, 64'd0);
`else
      op(LSU_OP_READ, BASE + 64'(DEPTH * 8), WIDTH_DOUBLE, 64'd0, 1'b0, 64'h0000_5A00_0000_0000);
`endif

      // Reset during WAIT of a write drops it
      op(LSU_OP_WRITE, BASE + 8, WIDTH_DOUBLE, 64'h1111_2222_3333_4444, 1'b0, 64'd0);
      issue(LSU_OP_WRITE, BASE + 8, WIDTH_WORD, 64'hDEAD_BEEF, 1'b0, 64'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("reset-in-wait rsp_valid", 0, 64'(o_rsp_valid), 64'd0);
      check("reset-in-wait req_ready", 0, 64'(o_req_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      op(LSU_OP_READ, BASE + 8, WIDTH_DOUBLE, 64'd0, 1'b0, 64'h1111_2222_3333_4444);

      // Upper word write and byte-enable masking of wide store data
      op(LSU_OP_WRITE, BASE + 12, WIDTH_WORD,   64'hCAFE_BABE, 1'b0, 64'd0);
      op(LSU_OP_READ,  BASE + 8,  WIDTH_DOUBLE, 64'd0, 1'b0, 64'hCAFE_BABE_3333_4444);
      op(LSU_OP_WRITE, BASE + 8,  WIDTH_BYTE,   64'hFFFF_FFFF_FFFF_FF77, 1'b0, 64'd0);
      op(LSU_OP_READ,  BASE + 8,  WIDTH_DOUBLE, 64'd0, 1'b0, 64'hCAFE_BABE_3333_4477);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
